// File: rtl/fir_mac_pkg.sv
// Shared definitions for the sequential FIR multiply-accumulate engine.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package fir_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int DEF_TAPS      = 8;
  localparam int DEF_ACC_WIDTH = 20;

  // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Smallest accumulator width that cannot overflow for a given tap count.
  function automatic int min_acc_width(input int taps);
    return 16 + clog2(taps);
  endfunction

endpackage

// File: rtl/vedic_8X8.sv
// Unsigned 8x8 Vedic (Urdhva-Tiryagbhyam) multiplier built from 2x2 -> 4x4 -> 8x8 partial blocks.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the operands.
// Ports: a, b - 8-bit unsigned operands; p - 16-bit unsigned product.
module vedic_8X8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // 2x2 block: the carry of the middle column feeds the top column.
  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic t1, t2, c1, t3;
    t1 = x[1] & y[0];
    t2 = x[0] & y[1];
    c1 = t1 & t2;
    t3 = x[1] & y[1];
    return {t3 & c1, t3 ^ c1, t1 ^ t2, x[0] & y[0]};
  endfunction

  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] m0, m1, m2, m3;
    m0 = mul2(x[1:0], y[1:0]);
    m1 = mul2(x[3:2], y[1:0]);
    m2 = mul2(x[1:0], y[3:2]);
    m3 = mul2(x[3:2], y[3:2]);
    return {4'b0, m0} + {2'b0, m1, 2'b0} + {2'b0, m2, 2'b0} + {m3, 4'b0};
  endfunction

  logic [7:0] w_q0, w_q1, w_q2, w_q3;

  assign w_q0 = mul4(a[3:0], b[3:0]);
  assign w_q1 = mul4(a[7:4], b[3:0]);
  assign w_q2 = mul4(a[3:0], b[7:4]);
  assign w_q3 = mul4(a[7:4], b[7:4]);

  assign p = {8'b0, w_q0} + {4'b0, w_q1, 4'b0} + {4'b0, w_q2, 4'b0} + {w_q3, 8'b0};

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequential FIR: shifts one sample into a TAPS-deep delay line, then walks one tap per cycle through a shared multiplier.
// Latency: out_valid rises TAPS+1 cycles after the sample accept; one sample per TAPS+2 cycles at best.
// Backpressure: out_ready low holds the OUT state with data stable; in_ready stays low until the result is taken.
// Ports: clk/rst_n (async active-low); in_valid/in_data/in_ready sample input; coef_we/coef_addr/coef_wdata
//        coefficient write (IDLE only, addr >= TAPS ignored); out_valid/out_data/out_ready result output.
module fir_mac_sequencer
  import fir_mac_pkg::*;
#(
  parameter int TAPS      = DEF_TAPS,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  input  logic                 coef_we,
  input  logic [3:0]           coef_addr,
  input  logic [7:0]           coef_wdata,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_data,
  input  logic                 out_ready
);

  localparam int IDX_W = clog2(TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  state_t               r_state, w_next;
  logic [7:0]           r_x [TAPS];
  logic [7:0]           r_h [TAPS];
  logic [IDX_W-1:0]     r_idx;
  logic [ACC_WIDTH-1:0] r_acc, r_out_data, w_sum;
  logic [7:0]           w_a, w_b;
  logic [15:0]          w_prod;
  logic                 w_accept, w_coef_wr, w_last;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_coef_wr = coef_we && (r_state == IDLE) && (int'(coef_addr) < TAPS);
  assign w_last    = (r_state == MAC) && (r_idx == LAST_IDX);

  assign w_a   = r_x[r_idx];
  assign w_b   = r_h[r_idx];
  assign w_sum = r_acc + ACC_WIDTH'(w_prod);

  vedic_8X8 u_mul (
    .a (w_a),
    .b (w_b),
    .p (w_prod)
  );

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = MAC;
      end
      MAC: begin
        if (r_idx == LAST_IDX) w_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign out_data = r_out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_acc <= '0;
        r_idx <= '0;
      end else if (r_state == MAC) begin
        r_acc <= w_sum;
        if (w_last) begin
          // Capture the finished sum separately so it survives the next accept clearing r_acc.
          r_out_data <= w_sum;
          r_idx      <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  // A same-cycle coefficient write lands here before the first MAC cycle reads r_h.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) r_h[k] <= '0;
    end else if (w_coef_wr) begin
      r_h[coef_addr[IDX_W-1:0]] <= coef_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
    end else if (w_accept) begin
      for (int k = TAPS - 1; k > 0; k--) r_x[k] <= r_x[k-1];
      r_x[0] <= in_data;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = 4'd0;
  logic [7:0]  coef_wdata = 8'd0;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.TAPS(8), .ACC_WIDTH(20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic write_coef(input logic [3:0] addr, input logic [7:0] val);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = addr; coef_wdata = val;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offers one sample with out_ready high; lat counts cycles from the accept cycle (0) to the out_valid cycle.
  task automatic run_sample(input logic [7:0] d, output logic [19:0] res, output int lat, output logic rdy_after);
    int guard;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    in_valid = 1'b0; lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    res = out_data;
    @(negedge clk);
    rdy_after = in_ready;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 20'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_impulse();
    logic [19:0] res; int lat; logic rdy;
    for (int k = 0; k < 8; k++) write_coef(4'(k), 8'(k + 1));
    for (int i = 0; i < 8; i++) begin
      run_sample((i == 0) ? 8'd1 : 8'd0, res, lat, rdy);
      checks++; if (res !== 20'(i + 1)) begin errors++; $display("FAIL impulse_out[%0d]: got %0d expected %0d", i, res, i + 1); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL impulse_latency[%0d]: got %0d expected 9", i, lat); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL impulse_ready_again[%0d]: got %b expected 1", i, rdy); end
    end
  endtask

  task automatic test_full_scale();
    logic [19:0] res; int lat; logic rdy;
    for (int k = 0; k < 8; k++) write_coef(4'(k), 8'd255);
    for (int i = 0; i < 8; i++) begin
      run_sample(8'd255, res, lat, rdy);
      checks++; if (res !== 20'((i + 1) * 65025)) begin errors++; $display("FAIL full_scale_out[%0d]: got %0d expected %0d", i, res, (i + 1) * 65025); end
    end
  endtask

  task automatic test_backpressure();
    logic [19:0] res; int lat; logic rdy;
    int guard;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd3;
    @(negedge clk);
    in_data = 8'd7;   // keep offering a different sample while busy
    guard = 0;
    while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_reach_out: got %b expected 1", out_valid); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 20'd455940) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%b data=%0d expected valid=1 data=455940", c, out_valid, out_data); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid: got %b expected 1", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_data !== 20'd455940) begin errors++; $display("FAIL bp_after_handshake: got valid=%b data=%0d expected valid=0 data=455940", out_valid, out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b expected 1", in_ready); end
    run_sample(8'd0, res, lat, rdy);
    checks++; if (res !== 20'd390915) begin errors++; $display("FAIL bp_not_accepted: got %0d expected 390915", res); end
  endtask

  task automatic test_coef_timing();
    logic [19:0] res; int lat; logic rdy;
    do_reset();
    write_coef(4'd0, 8'd5);
    // Write attempted across the whole MAC and OUT phases must be dropped.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd2;
    @(negedge clk);
    in_valid = 1'b0;
    coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 8'd9;
    lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    res = out_data;
    @(negedge clk);
    coef_we = 1'b0;
    checks++; if (res !== 20'd10) begin errors++; $display("FAIL coef_busy_pass: got %0d expected 10", res); end
    run_sample(8'd1, res, lat, rdy);
    checks++; if (res !== 20'd5) begin errors++; $display("FAIL coef_busy_dropped: got %0d expected 5", res); end
    // Write and accept in the same IDLE cycle: new coefficient used immediately.
    do_reset();
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 8'd9;
    in_valid = 1'b1; in_data = 8'd2;
    @(negedge clk);
    coef_we = 1'b0; in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    res = out_data;
    checks++; if (res !== 20'd18) begin errors++; $display("FAIL coef_same_cycle: got %0d expected 18", res); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL coef_same_cycle_latency: got %0d expected 9", lat); end
    @(negedge clk);
    write_coef(4'd8, 8'd100);   // out of range, must not alias onto h[0]
    run_sample(8'd1, res, lat, rdy);
    checks++; if (res !== 20'd9) begin errors++; $display("FAIL coef_addr_range: got %0d expected 9", res); end
  endtask

  task automatic test_reset_mid_mac();
    logic [19:0] res; int lat; logic rdy;
    int seen;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midmac_async_ctrl: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
    checks++; if (out_data !== 20'd0) begin errors++; $display("FAIL midmac_async_data: got %0d expected 0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midmac_no_output: got %0d valid cycles expected 0", seen); end
    run_sample(8'd7, res, lat, rdy);
    checks++; if (res !== 20'd0) begin errors++; $display("FAIL midmac_cleared: got %0d expected 0", res); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL midmac_latency: got %0d expected 9", lat); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_full_scale();
    test_backpressure();
    test_coef_timing();
    test_reset_mid_mac();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
